led_bit_serializer: RTL and testbench

Frame-level bit source that sits directly upstream of the WS2812 bit encoder. On a `start` trigger it reads NUM_LEDS 24-bit GRB pixel words from a synchronous-read pixel memory, presents them MSB-first one bit per encoder request, flags end of frame, times the latch (reset) low period, and returns to idle. It owns the `bit_to_transmit` / `all_bits_shifted` / `reset_finish` side of the encoder handshake.

---
 rtl/led_bit_serializer.sv | 162 ++++++++++++++++
 tb/tb_led_bit_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_bit_serializer.sv
// led_bit_serializer
// Frame-level bit source for a WS2812 bit encoder. When start is seen, it reads NUM_LEDS
// 24-bit GRB words from a synchronous-read pixel memory. It presents each word MSB-first,
// one bit per encoder request. After the last bit it waits for one more request, which
// marks the end of the final bit waveform. It then times the latch low period and
// returns to idle.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   start            frame trigger, level-sampled; held over a busy frame via start_pend
//   busy             high in every state except idle
//   frame_done       one-cycle pulse at the end of the latch period
//   pix_rd           one-cycle read strobe to pixel memory
//   pix_addr         pixel index, valid with pix_rd
//   pix_data         GRB word, valid the cycle after pix_rd
//   new_bit_rqst     encoder request: consume current bit, advance
//   bit_to_transmit  current bit, valid in SHIFT, 0 otherwise
//   all_bits_shifted level: last bit consumed, latch pending
//   reset_finish     one-cycle pulse ending the latch period
//   underrun         sticky: request arrived while no bit was ready
module led_bit_serializer #(
  parameter int unsigned NUM_LEDS     = 64,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned RESET_CYCLES = 2500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  input  logic              new_bit_rqst,
  output logic              bit_to_transmit,
  output logic              all_bits_shifted,
  output logic              reset_finish,
  output logic              underrun
);

  localparam int unsigned LatW = $clog2(RESET_CYCLES);
  localparam logic [LatW-1:0]   LatLast  = LatW'(RESET_CYCLES - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StDrain,
    StLatch
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic              abs_q, abs_d;
  logic              underrun_q, underrun_d;
  logic              start_pend_q, start_pend_d;

  always_comb begin
    state_d      = state_q;
    pix_addr_d   = pix_addr_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    abs_d        = abs_q;
    underrun_d   = underrun_q;
    start_pend_d = start_pend_q;

    // A trigger seen while busy is remembered so the next frame follows right after idle.
    if (start && (state_q != StIdle)) begin
      start_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start || start_pend_q) begin
          state_d      = StFetch;
          pix_addr_d   = '0;
          start_pend_d = 1'b0;
        end
      end
      StFetch: begin
        state_d = StLoad;
        if (new_bit_rqst) underrun_d = 1'b1;
      end
      StLoad: begin
        shreg_d   = pix_data;
        bit_cnt_d = 5'd0;
        state_d   = StShift;
        if (new_bit_rqst) underrun_d = 1'b1;
      end
      StShift: begin
        if (new_bit_rqst) begin
          shreg_d   = {shreg_q[22:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            if (pix_addr_q == AddrLast) begin
              abs_d   = 1'b1;
              state_d = StDrain;
            end else begin
              pix_addr_d = pix_addr_q + 1'b1;
              state_d    = StFetch;
            end
          end
        end
      end
      StDrain: begin
        // This request marks the end of the final bit waveform; the latch timer starts now.
        if (new_bit_rqst) begin
          lat_cnt_d = '0;
          state_d   = StLatch;
        end
      end
      StLatch: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LatLast) begin
          abs_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pix_addr_q   <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      abs_q        <= 1'b0;
      underrun_q   <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_addr_q   <= pix_addr_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      abs_q        <= abs_d;
      underrun_q   <= underrun_d;
      start_pend_q <= start_pend_d;
    end
  end

  // Outputs depend only on registers and state decode.
  assign busy             = (state_q != StIdle);
  assign pix_rd           = (state_q == StFetch);
  assign pix_addr         = pix_addr_q;
  assign bit_to_transmit  = (state_q == StShift) & shreg_q[23];
  assign all_bits_shifted = abs_q;
  assign reset_finish     = (state_q == StLatch) && (lat_cnt_q == LatLast);
  assign frame_done       = reset_finish;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_led_bit_serializer.sv
module tb_led_bit_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Instance A: two pixels
  logic        start_a = 1'b0, nbr_a = 1'b0;
  logic        busy_a, fd_a, rd_a, bit_a, abs_a, rf_a, ur_a;
  logic [5:0]  addr_a;
  logic [23:0] data_a = 24'h0;

  // Instance B: one pixel
  logic        start_b = 1'b0, nbr_b = 1'b0;
  logic        busy_b, fd_b, rd_b, bit_b, abs_b, rf_b, ur_b;
  logic [5:0]  addr_b;
  logic [23:0] data_b = 24'h0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_bit_serializer #(.NUM_LEDS(2), .ADDR_W(6), .RESET_CYCLES(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .frame_done(fd_a),
    .pix_rd(rd_a), .pix_addr(addr_a), .pix_data(data_a), .new_bit_rqst(nbr_a),
    .bit_to_transmit(bit_a), .all_bits_shifted(abs_a), .reset_finish(rf_a),
    .underrun(ur_a)
  );

  led_bit_serializer #(.NUM_LEDS(1), .ADDR_W(6), .RESET_CYCLES(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .frame_done(fd_b),
    .pix_rd(rd_b), .pix_addr(addr_b), .pix_data(data_b), .new_bit_rqst(nbr_b),
    .bit_to_transmit(bit_b), .all_bits_shifted(abs_b), .reset_finish(rf_b),
    .underrun(ur_b)
  );

  // Synchronous-read pixel memories
  always @(posedge clk) begin
    if (rd_a) data_a <= (addr_a == 6'd0) ? 24'hA50000 : 24'h00FF01;
    if (rd_b) data_b <= 24'hFFFFFF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on A, capturing the bit presented, then gap-1 quiet cycles.
  task automatic req_a(input int gap, output logic b);
    b     = bit_a;
    nbr_a = 1'b1;
    tick();
    nbr_a = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic req_b(input int gap, output logic b);
    b     = bit_b;
    nbr_b = 1'b1;
    tick();
    nbr_b = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"}, 48'(busy_a), 48'h0);
    chk({tag, "_frame_done"}, 48'(fd_a), 48'h0);
    chk({tag, "_pix_rd"}, 48'(rd_a), 48'h0);
    chk({tag, "_pix_addr"}, 48'(addr_a), 48'h0);
    chk({tag, "_bit"}, 48'(bit_a), 48'h0);
    chk({tag, "_abs"}, 48'(abs_a), 48'h0);
    chk({tag, "_reset_finish"}, 48'(rf_a), 48'h0);
    chk({tag, "_underrun"}, 48'(ur_a), 48'h0);
  endtask

  initial begin
    logic        b;
    logic [47:0] cap;
    int          rf_cnt;

    repeat (2) tick();
    rst = 1'b0;
    chk_reset_a("rst0");
    chk("rst0_b_busy", 48'(busy_b), 48'h0);

    // ---- Frame 1: requests every 8 cycles ----
    start_a = 1'b1;                       // cycle T
    tick();                               // T+1
    start_a = 1'b0;
    chk("f1_pix_rd", 48'(rd_a), 48'h1);
    chk("f1_addr0", 48'(addr_a), 48'h0);
    chk("f1_busy", 48'(busy_a), 48'h1);
    tick();                               // T+2 load
    chk("f1_load_rd", 48'(rd_a), 48'h0);
    tick();                               // T+3 first bit
    chk("f1_first_bit", 48'(bit_a), 48'h1);
    cap = '0;
    for (int i = 0; i < 48; i++) begin
      b     = bit_a;
      cap   = {cap[46:0], b};
      nbr_a = 1'b1;
      tick();
      nbr_a = 1'b0;
      if (i == 23) begin
        chk("f1_rd2", 48'(rd_a), 48'h1);
        chk("f1_addr1", 48'(addr_a), 48'h1);
      end
      if (i == 46) chk("f1_abs_early", 48'(abs_a), 48'h0);
      if (i == 47) chk("f1_abs_set", 48'(abs_a), 48'h1);
      repeat (7) tick();
    end
    chk("f1_bits", cap, 48'hA5000000FF01);
    chk("f1_underrun", 48'(ur_a), 48'h0);
    chk("f1_drain_bit", 48'(bit_a), 48'h0);
    nbr_a = 1'b1;                         // D: drain request
    tick();                               // D+1
    nbr_a = 1'b0;
    tick();                               // D+2: request inside latch, must be ignored
    nbr_a = 1'b1;
    tick();                               // D+3
    nbr_a = 1'b0;
    repeat (6) tick();                    // D+9
    chk("f1_rf_early", 48'(rf_a), 48'h0);
    tick();                               // D+10
    chk("f1_rf", 48'(rf_a), 48'h1);
    chk("f1_fd", 48'(fd_a), 48'h1);
    chk("f1_busy_latch", 48'(busy_a), 48'h1);
    tick();                               // D+11
    chk("f1_rf_off", 48'(rf_a), 48'h0);
    chk("f1_idle", 48'(busy_a), 48'h0);
    chk("f1_abs_clr", 48'(abs_a), 48'h0);
    chk("f1_ur_latch", 48'(ur_a), 48'h0);

    // ---- Frame 2: early request at the pixel boundary ----
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 23; i++) req_a(4, b);
    nbr_a = 1'b1;                         // R: consumes bit 23
    tick();                               // R+1 fetch, request held high
    chk("ur_in_fetch", 48'(rd_a), 48'h1);
    tick();                               // R+2 load
    nbr_a = 1'b0;
    chk("ur_addr", 48'(addr_a), 48'h1);
    chk("ur_flag", 48'(ur_a), 48'h1);
    tick();                               // R+3
    cap = '0;
    for (int i = 0; i < 24; i++) begin
      req_a(4, b);
      cap = {cap[46:0], b};
    end
    chk("ur_pix1_bits", cap, 48'h00FF01);
    chk("ur_abs", 48'(abs_a), 48'h1);
    req_a(11, b);                         // drain request, then D+11
    chk("ur_idle", 48'(busy_a), 48'h0);
    chk("ur_sticky", 48'(ur_a), 48'h1);

    // ---- Frame 3: start held high, back-to-back, then reset mid-frame ----
    start_a = 1'b1;
    tick();
    chk("bb_rd", 48'(rd_a), 48'h1);
    repeat (2) tick();
    for (int i = 0; i < 48; i++) req_a(4, b);
    nbr_a = 1'b1;                         // D
    tick();
    nbr_a = 1'b0;
    repeat (9) tick();                    // D+10
    chk("bb_fd", 48'(fd_a), 48'h1);
    tick();                               // D+11
    chk("bb_idle", 48'(busy_a), 48'h0);
    chk("bb_idle_rd", 48'(rd_a), 48'h0);
    tick();                               // D+12
    chk("bb_refetch", 48'(rd_a), 48'h1);
    chk("bb_addr0", 48'(addr_a), 48'h0);
    start_a = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 34; i++) req_a(4, b);
    chk("rst_bit10", 48'(bit_a), 48'h1);
    chk("rst_ur_before", 48'(ur_a), 48'h1);
    start_a = 1'b1;                       // sets a pending start
    tick();
    start_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_a("rst1");
    repeat (3) tick();
    chk("rst_pend_gone", 48'(busy_a), 48'h0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rst_fresh_rd", 48'(rd_a), 48'h1);
    chk("rst_fresh_addr", 48'(addr_a), 48'h0);

    // ---- Instance B: single all-ones pixel ----
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_rd", 48'(rd_b), 48'h1);
    repeat (2) tick();
    cap = '0;
    for (int i = 0; i < 24; i++) begin
      req_b(4, b);
      cap = {cap[46:0], b};
    end
    chk("b_bits", cap, 48'hFFFFFF);
    chk("b_abs", 48'(abs_b), 48'h1);
    chk("b_drain_busy", 48'(busy_b), 48'h1);
    nbr_b = 1'b1;
    tick();
    nbr_b = 1'b0;
    rf_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (rf_b) rf_cnt++;
      tick();
    end
    chk("b_rf_once", 48'(rf_cnt), 48'h1);
    chk("b_idle", 48'(busy_b), 48'h0);
    chk("b_underrun", 48'(ur_b), 48'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
